// File: rtl/game_state_sequencer.sv
// Game-flow controller: lives, score, level, invulnerability window and movement/flame gating.
// Defining EXTRA_LIFE_EN adds a bonus life each time the score passes a rising threshold.
module game_state_sequencer #(
`ifdef EXTRA_LIFE_EN
  parameter int EXTRA_LIFE_SCORE   = 1000,
`endif
  parameter int LIVES_INIT         = 3,
  parameter int LIVES_MAX          = 5,
  parameter int INVULN_FRAMES      = 60,
  parameter int LEVEL_PAUSE_FRAMES = 90,
  parameter int MONEY_POINTS       = 50,
  parameter int WALL_POINTS        = 10,
  parameter int SCORE_W            = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               hit_flames,
  input  logic               hit_mine,
  input  logic               pickup_potion,
  input  logic               pickup_money,
  input  logic               wall_destroyed,
  input  logic               sewer_reached,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               player_en,
  output logic               flames_en,
  output logic               player_visible,
  output logic               level_done,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PLAY       = 3'd1,
    S_HIT        = 3'd2,
    S_LEVEL_DONE = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_t;

  localparam int CNT_MAX = (INVULN_FRAMES > LEVEL_PAUSE_FRAMES) ? INVULN_FRAMES : LEVEL_PAUSE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0]       LIVES_INIT_L = 3'(LIVES_INIT);
  localparam logic [2:0]       LIVES_MAX_L  = 3'(LIVES_MAX);
  localparam logic [CNT_W-1:0] INVULN_L     = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0] PAUSE_L      = CNT_W'(LEVEL_PAUSE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [SCORE_W:0] MONEY_L      = (SCORE_W + 1)'(MONEY_POINTS);
  localparam logic [SCORE_W:0] WALL_L       = (SCORE_W + 1)'(WALL_POINTS);
`ifdef EXTRA_LIFE_EN
  localparam logic [SCORE_W:0] THR_STEP     = (SCORE_W + 1)'(EXTRA_LIFE_SCORE);
`endif

  state_t             r_state;
  logic [2:0]         r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_level;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_player_en;
  logic               r_flames_en;
  logic               r_player_visible;
  logic               r_level_done;
  logic               r_game_over;
`ifdef EXTRA_LIFE_EN
  logic [SCORE_W:0]   r_threshold;
  logic [SCORE_W:0]   w_thr_nxt;
`endif

  state_t             w_state_nxt;
  logic [2:0]         w_lives_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [3:0]         w_level_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_level_done_nxt;
  logic               w_hit;
  logic               w_active;
  logic [SCORE_W:0]   w_score_sum;
  logic [SCORE_W-1:0] w_score_sat;

  function automatic logic [2:0] lives_inc(input logic [2:0] l);
    return (l >= LIVES_MAX_L) ? l : l + 3'd1;
  endfunction

  assign w_hit    = hit_flames | hit_mine;
  assign w_active = (r_state == S_PLAY) || (r_state == S_HIT);

  // One spare carry bit is enough because each pickup is worth less than the score range.
  assign w_score_sum = {1'b0, r_score}
                     + (pickup_money   ? MONEY_L : '0)
                     + (wall_destroyed ? WALL_L  : '0);
  assign w_score_sat = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt      = r_state;
    w_lives_nxt      = r_lives;
    w_score_nxt      = r_score;
    w_level_nxt      = r_level;
    w_cnt_nxt        = r_cnt;
    w_level_done_nxt = 1'b0;

    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (start_game) begin
          w_lives_nxt = LIVES_INIT_L;
          w_score_nxt = '0;
          w_level_nxt = 4'd0;
          w_state_nxt = S_PLAY;
        end
      end
      S_PLAY, S_HIT: begin
        w_score_nxt = w_score_sat;
        if ((r_state == S_PLAY) && w_hit) begin
          // Simultaneous hits cost one life; the hit also pre-empts potion and sewer.
          if (r_lives <= 3'd1) begin
            w_lives_nxt = 3'd0;
            w_state_nxt = S_GAME_OVER;
          end else begin
            w_lives_nxt = r_lives - 3'd1;
            w_cnt_nxt   = INVULN_L;
            w_state_nxt = S_HIT;
          end
        end else begin
          if (pickup_potion) w_lives_nxt = lives_inc(r_lives);
          if (sewer_reached) begin
            w_cnt_nxt        = PAUSE_L;
            w_level_done_nxt = 1'b1;
            w_state_nxt      = S_LEVEL_DONE;
          end else if ((r_state == S_HIT) && startOfFrame) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) w_state_nxt = S_PLAY;
          end
        end
      end
      S_LEVEL_DONE: begin
        if (startOfFrame) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_level_nxt = (r_level == 4'hF) ? r_level : r_level + 4'd1;
            w_state_nxt = S_PLAY;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef EXTRA_LIFE_EN
    w_thr_nxt = r_threshold;
    if (((r_state == S_IDLE) || (r_state == S_GAME_OVER)) && start_game) begin
      w_thr_nxt = THR_STEP;
    end else if (w_active && (w_state_nxt != S_GAME_OVER) &&
                 ({1'b0, w_score_nxt} >= r_threshold)) begin
      w_lives_nxt = lives_inc(w_lives_nxt);
      w_thr_nxt   = r_threshold + THR_STEP;
    end
`endif
  end

  // Flags are registered from the next-state values so they change together with state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state          <= S_IDLE;
      r_lives          <= LIVES_INIT_L;
      r_score          <= '0;
      r_level          <= 4'd0;
      r_cnt            <= '0;
      r_player_en      <= 1'b0;
      r_flames_en      <= 1'b0;
      r_player_visible <= 1'b1;
      r_level_done     <= 1'b0;
      r_game_over      <= 1'b0;
`ifdef EXTRA_LIFE_EN
      r_threshold      <= THR_STEP;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_lives          <= w_lives_nxt;
      r_score          <= w_score_nxt;
      r_level          <= w_level_nxt;
      r_cnt            <= w_cnt_nxt;
      r_player_en      <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_HIT);
      r_flames_en      <= (w_state_nxt == S_PLAY);
      r_player_visible <= (w_state_nxt == S_HIT) ? ~w_cnt_nxt[2] : 1'b1;
      r_level_done     <= w_level_done_nxt;
      r_game_over      <= (w_state_nxt == S_GAME_OVER);
`ifdef EXTRA_LIFE_EN
      r_threshold      <= w_thr_nxt;
`endif
    end
  end

  assign state          = r_state;
  assign lives          = r_lives;
  assign score          = r_score;
  assign level          = r_level;
  assign player_en      = r_player_en;
  assign flames_en      = r_flames_en;
  assign player_visible = r_player_visible;
  assign level_done     = r_level_done;
  assign game_over      = r_game_over;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Self-checking bench for game_state_sequencer: directed scenarios then random pulses
// against a behavioural model of the game rules.
module tb_game_state_sequencer;

  localparam int LIVES_INIT         = 3;
  localparam int LIVES_MAX          = 5;
  localparam int INVULN_FRAMES      = 60;
  localparam int LEVEL_PAUSE_FRAMES = 90;
  localparam int MONEY_POINTS       = 50;
  localparam int WALL_POINTS        = 10;
  localparam int SCORE_MAX          = 65535;
  localparam int EXTRA_LIFE_SCORE   = 1000;

  localparam int IDLE = 0, PLAY = 1, HIT = 2, LEVEL_DONE = 3, GAME_OVER = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        start_game = 1'b0;
  logic        hit_flames = 1'b0;
  logic        hit_mine = 1'b0;
  logic        pickup_potion = 1'b0;
  logic        pickup_money = 1'b0;
  logic        wall_destroyed = 1'b0;
  logic        sewer_reached = 1'b0;
  logic [2:0]  state;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [3:0]  level;
  logic        player_en;
  logic        flames_en;
  logic        player_visible;
  logic        level_done;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the game rules.
  int m_state = IDLE;
  int m_lives = 0;
  int m_score = 0;
  int m_level = 0;
  int m_cnt   = 0;
  int m_thr   = EXTRA_LIFE_SCORE;
  bit m_vis   = 1'b1;
  bit m_ld    = 1'b0;

  game_state_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .start_game     (start_game),
    .hit_flames     (hit_flames),
    .hit_mine       (hit_mine),
    .pickup_potion  (pickup_potion),
    .pickup_money   (pickup_money),
    .wall_destroyed (wall_destroyed),
    .sewer_reached  (sewer_reached),
    .state          (state),
    .lives          (lives),
    .score          (score),
    .level          (level),
    .player_en      (player_en),
    .flames_en      (flames_en),
    .player_visible (player_visible),
    .level_done     (level_done),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int ns, nl, nsc, nlv, nc, nthr;
    bit ld;
    ns = m_state; nl = m_lives; nsc = m_score; nlv = m_level; nc = m_cnt; nthr = m_thr; ld = 1'b0;
    if (reset) begin
      ns = IDLE; nl = LIVES_INIT; nsc = 0; nlv = 0; nc = 0; nthr = EXTRA_LIFE_SCORE;
    end else if (m_state == IDLE || m_state == GAME_OVER) begin
      if (start_game) begin
        nl = LIVES_INIT; nsc = 0; nlv = 0; nthr = EXTRA_LIFE_SCORE; ns = PLAY;
      end
    end else if (m_state == LEVEL_DONE) begin
      if (startOfFrame) begin
        nc = m_cnt - 1;
        if (nc == 0) begin
          ns  = PLAY;
          nlv = (m_level < 15) ? m_level + 1 : 15;
        end
      end
    end else begin
      nsc = m_score + (pickup_money ? MONEY_POINTS : 0) + (wall_destroyed ? WALL_POINTS : 0);
      if (nsc > SCORE_MAX) nsc = SCORE_MAX;
      if (m_state == PLAY && (hit_flames || hit_mine)) begin
        if (m_lives == 1) begin
          nl = 0; ns = GAME_OVER;
        end else begin
          nl = m_lives - 1; nc = INVULN_FRAMES; ns = HIT;
        end
      end else begin
        if (pickup_potion && nl < LIVES_MAX) nl = nl + 1;
        if (sewer_reached) begin
          ns = LEVEL_DONE; nc = LEVEL_PAUSE_FRAMES; ld = 1'b1;
        end else if (m_state == HIT && startOfFrame) begin
          nc = m_cnt - 1;
          if (nc == 0) ns = PLAY;
        end
      end
`ifdef EXTRA_LIFE_EN
      if (ns != GAME_OVER && nsc >= m_thr) begin
        if (nl < LIVES_MAX) nl = nl + 1;
        nthr = m_thr + EXTRA_LIFE_SCORE;
      end
`endif
    end
    m_state = ns; m_lives = nl; m_score = nsc; m_level = nlv; m_cnt = nc; m_thr = nthr; m_ld = ld;
    // Blink: visible while bit 2 of the remaining frame count is clear.
    m_vis = (ns == HIT) ? (((nc / 4) % 2) == 0) : 1'b1;
  endtask

  task automatic compare_all();
    check("state",          int'(state),          m_state);
    check("lives",          int'(lives),          m_lives);
    check("score",          int'(score),          m_score);
    check("level",          int'(level),          m_level);
    check("player_en",      int'(player_en),      int'(m_state == PLAY || m_state == HIT));
    check("flames_en",      int'(flames_en),      int'(m_state == PLAY));
    check("player_visible", int'(player_visible), int'(m_vis));
    check("level_done",     int'(level_done),     int'(m_ld));
    check("game_over",      int'(game_over),      int'(m_state == GAME_OVER));
  endtask

  // Drive one clock of inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cycle(input bit sof, input bit st, input bit hf, input bit hm,
                       input bit pp, input bit pm, input bit wd, input bit sw);
    startOfFrame = sof; start_game = st; hit_flames = hf; hit_mine = hm;
    pickup_potion = pp; pickup_money = pm; wall_destroyed = wd; sewer_reached = sw;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    check("rst_state", int'(state), IDLE);
    check("rst_lives", int'(lives), 3);
    check("rst_visible", int'(player_visible), 1);

    // Game start
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check("start_state", int'(state), PLAY);
    check("start_lives", int'(lives), 3);
    check("start_player_en", int'(player_en), 1);
    check("start_flames_en", int'(flames_en), 1);

    // Hit, ignored second hit, invulnerability expiry
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check("hit_lives", int'(lives), 2);
    check("hit_state", int'(state), HIT);
    check("hit_flames_en", int'(flames_en), 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    check("hit_ignored_lives", int'(lives), 2);
    frames(INVULN_FRAMES - 1);
    check("invuln_hold", int'(state), HIT);
    frames(1);
    check("invuln_end", int'(state), PLAY);

    // Potions saturate at LIVES_MAX
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);
    check("potion_five", int'(lives), 5);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    check("potion_cap", int'(lives), 5);

    // Level transition
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check("ld_pulse", int'(level_done), 1);
    check("ld_state", int'(state), LEVEL_DONE);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("ld_pulse_end", int'(level_done), 0);
    frames(LEVEL_PAUSE_FRAMES - 1);
    check("ld_hold", int'(state), LEVEL_DONE);
    frames(1);
    check("ld_next_level", int'(level), 1);
    check("ld_back_play", int'(state), PLAY);

    // Score: simultaneous pickups and saturation
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    check("score_both", int'(score), 60);
    for (int i = 0; i < 1091; i++) cycle(0, 0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("score_65530", int'(score), 65530);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("score_sat", int'(score), 65535);

    // Drain lives to 1, then hit with sewer in the same clock
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 0, 0);
      frames(INVULN_FRAMES);
    end
    check("lives_one", int'(lives), 1);
    cycle(0, 0, 0, 1, 0, 0, 0, 1);
    check("go_lives", int'(lives), 0);
    check("go_state", int'(state), GAME_OVER);
    check("go_flag", int'(game_over), 1);
    check("go_no_ld", int'(level_done), 0);

    // Restart; score crosses 1000 with two lives
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check("restart_score", int'(score), 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    frames(INVULN_FRAMES);
    for (int i = 0; i < 19; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("score_990", int'(score), 990);
    check("lives_two", int'(lives), 2);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("score_1040", int'(score), 1040);
`ifdef EXTRA_LIFE_EN
    check("bonus_life", int'(lives), 3);
`else
    check("no_bonus_life", int'(lives), 2);
`endif

    // Level saturates at 15
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      frames(LEVEL_PAUSE_FRAMES);
    end
    check("level_sat", int'(level), 15);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
